// File: rtl/pio_fifo.sv
// pio_fifo: TX/RX FIFO pair between the host bus and one PIO state machine.
// The host fills TX and the machine pulls from it; the machine pushes into RX
// and the host drains it. Both heads are show-ahead and read as 0 when empty.
// Optional feature macro: PIO_FIFO_JOIN_EN builds the join logic that merges
// both storages into one double-depth FIFO for TX or RX.
module pio_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       machine_en,
  input  logic                       mc_pull,
  output logic [31:0]                mc_din,
  output logic                       mc_empty,
  input  logic                       mc_push,
  input  logic [31:0]                mc_dout,
  output logic                       mc_full,
  input  logic                       tx_wr,
  input  logic [31:0]                tx_wdata,
  output logic                       tx_full,
  input  logic                       rx_rd,
  output logic [31:0]                rx_rdata,
  output logic                       rx_empty,
  output logic [$clog2(DEPTH)+1:0]   tx_level,
  output logic [$clog2(DEPTH)+1:0]   rx_level,
  input  logic                       join_tx,
  input  logic                       join_rx,
  input  logic                       flags_clr,
  output logic                       tx_over,
  output logic                       rx_under,
  output logic                       tx_stall,
  output logic                       rx_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // pointer width, spans the joined depth
  localparam int LW = AW + 2;   // level width, holds 0 .. 2*DEPTH

  typedef enum logic [1:0] {
    MODE_SPLIT   = 2'b00,
    MODE_TX_JOIN = 2'b01,
    MODE_RX_JOIN = 2'b10
  } mode_t;

  // Shared storage: lower half belongs to TX, upper half to RX when split.
  logic [31:0]   mem [0:2*DEPTH-1];

  mode_t         mode_s;
  mode_t         mode_r;
  logic          flush_s;

  logic [PW-1:0] tx_rd_ptr_r;
  logic [PW-1:0] tx_wr_ptr_r;
  logic [PW-1:0] rx_rd_ptr_r;
  logic [PW-1:0] rx_wr_ptr_r;
  logic [LW-1:0] tx_level_r;
  logic [LW-1:0] rx_level_r;

  logic [LW-1:0] tx_depth_s;
  logic [LW-1:0] rx_depth_s;
  logic          tx_on_s;
  logic          rx_on_s;
  logic          rx_upper_s;

  logic          tx_wr_acc_s;
  logic          tx_rd_acc_s;
  logic          rx_wr_acc_s;
  logic          rx_rd_acc_s;
  logic [PW-1:0] rx_waddr_s;
  logic [PW-1:0] rx_raddr_s;

  // Advance a pointer, wrapping at the active depth.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p,
                                             input logic [LW-1:0] depth);
    if ({1'b0, p} == depth - LW'(1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

`ifdef PIO_FIFO_JOIN_EN
  // Effective join mode: exactly one select set joins, otherwise split.
  always_comb begin
    mode_s = MODE_SPLIT;
    if (join_tx && !join_rx) begin
      mode_s = MODE_TX_JOIN;
    end else if (join_rx && !join_tx) begin
      mode_s = MODE_RX_JOIN;
    end else begin
      mode_s = MODE_SPLIT;
    end
  end
`else
  logic unused_join;
  assign unused_join = join_tx ^ join_rx;

  // Join selects are ignored in this build; the pair is always split.
  always_comb begin
    mode_s = MODE_SPLIT;
  end
`endif

  assign flush_s = (mode_s != mode_r);

  // Per-mode depth, enable and RX storage placement, from the registered mode.
  always_comb begin
    tx_depth_s = LW'(DEPTH);
    rx_depth_s = LW'(DEPTH);
    tx_on_s    = 1'b1;
    rx_on_s    = 1'b1;
    rx_upper_s = 1'b1;
    case (mode_r)
      MODE_TX_JOIN: begin
        tx_depth_s = LW'(2 * DEPTH);
        rx_on_s    = 1'b0;
      end
      MODE_RX_JOIN: begin
        rx_depth_s = LW'(2 * DEPTH);
        tx_on_s    = 1'b0;
        rx_upper_s = 1'b0;
      end
      default: begin
        tx_depth_s = LW'(DEPTH);
        rx_depth_s = LW'(DEPTH);
      end
    endcase
  end

  // Status comes only from registered levels; a disabled side looks full and empty.
  assign mc_empty = !tx_on_s || (tx_level_r == LW'(0));
  assign tx_full  = !tx_on_s || (tx_level_r == tx_depth_s);
  assign rx_empty = !rx_on_s || (rx_level_r == LW'(0));
  assign mc_full  = !rx_on_s || (rx_level_r == rx_depth_s);
  assign tx_level = tx_level_r;
  assign rx_level = rx_level_r;

  assign tx_wr_acc_s = tx_wr && !tx_full;
  assign tx_rd_acc_s = machine_en && mc_pull && !mc_empty;
  assign rx_wr_acc_s = machine_en && mc_push && !mc_full;
  assign rx_rd_acc_s = rx_rd && !rx_empty;

  assign rx_waddr_s = rx_upper_s ? (rx_wr_ptr_r | PW'(DEPTH)) : rx_wr_ptr_r;
  assign rx_raddr_s = rx_upper_s ? (rx_rd_ptr_r | PW'(DEPTH)) : rx_rd_ptr_r;

  assign mc_din   = mc_empty ? 32'h0 : mem[tx_rd_ptr_r];
  assign rx_rdata = rx_empty ? 32'h0 : mem[rx_raddr_s];

  // Storage writes; the RAM itself is never reset.
  always_ff @(posedge clk) begin
    if (tx_wr_acc_s) begin
      mem[tx_wr_ptr_r] <= tx_wdata;
    end
    if (rx_wr_acc_s) begin
      mem[rx_waddr_s] <= mc_dout;
    end
  end

  // Pointers, levels and mode; a change of join mode empties both FIFOs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r      <= MODE_SPLIT;
      tx_rd_ptr_r <= PW'(0);
      tx_wr_ptr_r <= PW'(0);
      rx_rd_ptr_r <= PW'(0);
      rx_wr_ptr_r <= PW'(0);
      tx_level_r  <= LW'(0);
      rx_level_r  <= LW'(0);
    end else if (flush_s) begin
      mode_r      <= mode_s;
      tx_rd_ptr_r <= PW'(0);
      tx_wr_ptr_r <= PW'(0);
      rx_rd_ptr_r <= PW'(0);
      rx_wr_ptr_r <= PW'(0);
      tx_level_r  <= LW'(0);
      rx_level_r  <= LW'(0);
    end else begin
      if (tx_wr_acc_s) tx_wr_ptr_r <= ptr_next(tx_wr_ptr_r, tx_depth_s);
      if (tx_rd_acc_s) tx_rd_ptr_r <= ptr_next(tx_rd_ptr_r, tx_depth_s);
      if (rx_wr_acc_s) rx_wr_ptr_r <= ptr_next(rx_wr_ptr_r, rx_depth_s);
      if (rx_rd_acc_s) rx_rd_ptr_r <= ptr_next(rx_rd_ptr_r, rx_depth_s);
      case ({tx_wr_acc_s, tx_rd_acc_s})
        2'b10:   tx_level_r <= tx_level_r + LW'(1);
        2'b01:   tx_level_r <= tx_level_r - LW'(1);
        default: tx_level_r <= tx_level_r;
      endcase
      case ({rx_wr_acc_s, rx_rd_acc_s})
        2'b10:   rx_level_r <= rx_level_r + LW'(1);
        2'b01:   rx_level_r <= rx_level_r - LW'(1);
        default: rx_level_r <= rx_level_r;
      endcase
    end
  end

  // Sticky error/stall flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_over  <= 1'b0;
      rx_under <= 1'b0;
      tx_stall <= 1'b0;
      rx_stall <= 1'b0;
    end else if (flags_clr) begin
      tx_over  <= 1'b0;
      rx_under <= 1'b0;
      tx_stall <= 1'b0;
      rx_stall <= 1'b0;
    end else begin
      if (tx_wr && tx_full)                      tx_over  <= 1'b1;
      if (rx_rd && rx_empty)                     rx_under <= 1'b1;
      if (machine_en && mc_pull && mc_empty)     tx_stall <= 1'b1;
      if (machine_en && mc_push && mc_full)      rx_stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pio_fifo.sv
// Testbench for pio_fifo: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_pio_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          machine_en, mc_pull, mc_push, tx_wr, rx_rd;
  logic          join_tx, join_rx, flags_clr;
  logic [31:0]   mc_dout, tx_wdata;
  logic [31:0]   mc_din, rx_rdata;
  logic          mc_empty, mc_full, tx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;
  logic          tx_over, rx_under, tx_stall, rx_stall;

  int checks   = 0;
  int failures = 0;

  pio_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .machine_en(machine_en),
    .mc_pull(mc_pull), .mc_din(mc_din), .mc_empty(mc_empty),
    .mc_push(mc_push), .mc_dout(mc_dout), .mc_full(mc_full),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
    .tx_level(tx_level), .rx_level(rx_level),
    .join_tx(join_tx), .join_rx(join_rx), .flags_clr(flags_clr),
    .tx_over(tx_over), .rx_under(rx_under), .tx_stall(tx_stall), .rx_stall(rx_stall)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: plain queues ----------------
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [3:0]  m_flags;   // {tx_over, rx_under, tx_stall, rx_stall}
  int          m_mode;    // 0 split, 1 TX joined, 2 RX joined

  function automatic int eff_mode();
`ifdef PIO_FIFO_JOIN_EN
    if (join_tx && !join_rx) return 1;
    if (join_rx && !join_tx) return 2;
`endif
    return 0;
  endfunction

  function automatic logic m_tx_full();
    if (m_mode == 2) return 1'b1;
    return tx_q.size() == ((m_mode == 1) ? 2 * DEPTH : DEPTH);
  endfunction
  function automatic logic m_mc_empty();
    return (m_mode == 2) || (tx_q.size() == 0);
  endfunction
  function automatic logic m_mc_full();
    if (m_mode == 1) return 1'b1;
    return rx_q.size() == ((m_mode == 2) ? 2 * DEPTH : DEPTH);
  endfunction
  function automatic logic m_rx_empty();
    return (m_mode == 1) || (rx_q.size() == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":mc_empty"}, {31'd0, mc_empty}, {31'd0, m_mc_empty()});
    chk({tag, ":tx_full"},  {31'd0, tx_full},  {31'd0, m_tx_full()});
    chk({tag, ":mc_full"},  {31'd0, mc_full},  {31'd0, m_mc_full()});
    chk({tag, ":rx_empty"}, {31'd0, rx_empty}, {31'd0, m_rx_empty()});
    chk({tag, ":tx_level"}, 32'(tx_level), 32'(tx_q.size()));
    chk({tag, ":rx_level"}, 32'(rx_level), 32'(rx_q.size()));
    chk({tag, ":mc_din"},   mc_din,   m_mc_empty() ? 32'h0 : tx_q[0]);
    chk({tag, ":rx_rdata"}, rx_rdata, m_rx_empty() ? 32'h0 : rx_q[0]);
    chk({tag, ":flags"}, {28'd0, tx_over, rx_under, tx_stall, rx_stall}, {28'd0, m_flags});
  endtask

  task automatic drive(input logic w, input logic [31:0] wd, input logic en,
                       input logic pl, input logic ps, input logic [31:0] dt,
                       input logic rd, input logic clr);
    tx_wr = w; tx_wdata = wd; machine_en = en; mc_pull = pl;
    mc_push = ps; mc_dout = dt; rx_rd = rd; flags_clr = clr;
  endtask

  // Update the model for the coming edge, then advance to the next negedge.
  task automatic step();
    logic tf, me, mf, re;
    int   nm;
    tf = m_tx_full(); me = m_mc_empty(); mf = m_mc_full(); re = m_rx_empty();
    nm = eff_mode();
    if (flags_clr) begin
      m_flags = 4'b0000;
    end else begin
      if (tx_wr && tf)                     m_flags[3] = 1'b1;
      if (rx_rd && re)                     m_flags[2] = 1'b1;
      if (machine_en && mc_pull && me)     m_flags[1] = 1'b1;
      if (machine_en && mc_push && mf)     m_flags[0] = 1'b1;
    end
    if (nm != m_mode) begin
      tx_q.delete(); rx_q.delete(); m_mode = nm;
    end else begin
      if (machine_en && mc_pull && !me) void'(tx_q.pop_front());
      if (tx_wr && !tf)                 tx_q.push_back(tx_wdata);
      if (rx_rd && !re)                 void'(rx_q.pop_front());
      if (machine_en && mc_push && !mf) rx_q.push_back(mc_dout);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          w;  logic [31:0] wd; logic en; logic pl;
    logic          ps; logic [31:0] dt; logic rd; logic clr;
    logic [LW-1:0] e_txl; logic [31:0] e_din; logic e_mce; logic e_txf;
    logic [LW-1:0] e_rxl; logic [31:0] e_rdata; logic e_rxe; logic [3:0] e_flags;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1, 32'h11, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000};
    vt[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd2, 32'h11, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000};
    vt[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd3, 32'h11, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000};
    vt[3]  = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd4, 32'h11, 1'b0, 1'b1, 4'd0, 32'h0, 1'b1, 4'b0000};
    vt[4]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd4, 32'h11, 1'b0, 1'b1, 4'd0, 32'h0, 1'b1, 4'b1000};
    vt[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd3, 32'h22, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b1000};
    vt[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd2, 32'h33, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b1000};
    vt[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1, 32'h44, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b1000};
    vt[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'b1000};
    vt[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'b1010};
    vt[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'h0,  1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000};
    vt[11] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000};
    vt[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hA5, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd1, 32'hA5, 1'b0, 4'b0100};
    vt[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hB6, 1'b0, 1'b1, 4'd0, 32'h0, 1'b1, 1'b0, 4'd2, 32'hA5, 1'b0, 4'b0000};
  end

  initial begin
    logic [31:0] exp_head;
    string       tag;

    tx_q.delete(); rx_q.delete(); m_flags = 4'b0000; m_mode = 0;
    reset = 1'b1; join_tx = 1'b0; join_rx = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state before any edge with reset released.
    chk("rst:mc_empty", {31'd0, mc_empty}, 32'd1);
    chk("rst:rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("rst:tx_full",  {31'd0, tx_full},  32'd0);
    chk("rst:mc_full",  {31'd0, mc_full},  32'd0);
    chk("rst:tx_level", 32'(tx_level), 32'd0);
    chk("rst:rx_level", 32'(rx_level), 32'd0);
    chk("rst:mc_din",   mc_din, 32'h0);
    chk("rst:rx_rdata", rx_rdata, 32'h0);
    chk("rst:flags", {28'd0, tx_over, rx_under, tx_stall, rx_stall}, 32'd0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].w, vt[i].wd, vt[i].en, vt[i].pl, vt[i].ps, vt[i].dt, vt[i].rd, vt[i].clr);
      step();
      tag = $sformatf("vec%0d", i);
      chk({tag, ":tx_level"}, 32'(tx_level), 32'(vt[i].e_txl));
      chk({tag, ":mc_din"},   mc_din, vt[i].e_din);
      chk({tag, ":mc_empty"}, {31'd0, mc_empty}, {31'd0, vt[i].e_mce});
      chk({tag, ":tx_full"},  {31'd0, tx_full},  {31'd0, vt[i].e_txf});
      chk({tag, ":rx_level"}, 32'(rx_level), 32'(vt[i].e_rxl));
      chk({tag, ":rx_rdata"}, rx_rdata, vt[i].e_rdata);
      chk({tag, ":rx_empty"}, {31'd0, rx_empty}, {31'd0, vt[i].e_rxe});
      chk({tag, ":flags"}, {28'd0, tx_over, rx_under, tx_stall, rx_stall}, {28'd0, vt[i].e_flags});
    end

    // RX at level 2: simultaneous push and read wraps the pointers twice.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0);
      step();
      exp_head = (i == 0) ? 32'hB6 : 32'hC0 + 32'(i - 1);
      chk($sformatf("wrap%0d:rx_level", i), 32'(rx_level), 32'd2);
      chk($sformatf("wrap%0d:rx_rdata", i), rx_rdata, exp_head);
    end
    check_model("wrap_end");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
    end

`ifdef PIO_FIFO_JOIN_EN
    // TX joined: double depth, RX reported unavailable, leaving flushes.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    join_tx = 1'b1;
    step();
    check_model("join_enter");
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      check_model($sformatf("join_wr%0d", i));
    end
    chk("join:tx_level", 32'(tx_level), 32'd8);
    chk("join:tx_over",  {31'd0, tx_over},  32'd1);
    chk("join:mc_full",  {31'd0, mc_full},  32'd1);
    chk("join:rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("join:head",     mc_din, 32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    join_tx = 1'b0;
    step();
    chk("unjoin:tx_level", 32'(tx_level), 32'd0);
    check_model("unjoin");
`endif

    // Bring TX to level 3, then assert reset asynchronously mid-cycle.
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
    end
    chk("pre_areset:tx_level", 32'(tx_level), 32'd3);
    check_model("pre_areset");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("areset:mc_empty", {31'd0, mc_empty}, 32'd1);
    chk("areset:tx_full",  {31'd0, tx_full},  32'd0);
    chk("areset:mc_full",  {31'd0, mc_full},  32'd0);
    chk("areset:rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("areset:tx_level", 32'(tx_level), 32'd0);
    chk("areset:rx_level", 32'(rx_level), 32'd0);
    chk("areset:mc_din",   mc_din, 32'h0);
    chk("areset:rx_rdata", rx_rdata, 32'h0);
    chk("areset:flags", {28'd0, tx_over, rx_under, tx_stall, rx_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tx_q.delete(); rx_q.delete(); m_flags = 4'b0000; m_mode = 0;

    // Contents were discarded: a new entry becomes the head.
    drive(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("post_reset:mc_din", mc_din, 32'hBEEF);
    check_model("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
